adder_decomposable_accumulator: RTL and testbench
=================================================

# adder_decomposable_accumulator

Sequential accumulation stage for the decomposable adder in the posit PE datapath. Accepts a packet of 32-bit operand words over a valid/ready handshake and drives the adder with each word plus its own accumulator register. Captures the lane-appropriate sum according to the precision mode and presents the packet total, per-lane overflow flags and a beat count downstream.

## Interface
- `EACH_ADDER_LEN`, default 8: width of one adder lane.
- `N_ADDERS`, default 4: number of lanes. Fixed at 4.
- `ACC_CNT_W`, default 8: width of the beat counter.

Ports (TOTAL = `EACH_ADDER_LEN*N_ADDERS`):
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mode`  in  `PRECISION_CONFIG_L`  precision for the packet; sampled on its first beat.
- `in_valid`  in  1  operand word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  TOTAL  operand word.
- `in_last`  in  1  marks the last word of the packet.
- `add_in0`  out  TOTAL  equals `in_data`; drives adder `in0`.
- `add_in1`  out  TOTAL  equals accumulator register; drives adder `in1`.
- `add_mode`  out  `PRECISION_CONFIG_L`  `mode` in IDLE, latched mode otherwise.
- `add_out_quart`  in  `[N_ADDERS-1:0][EACH_ADDER_LEN:0]`  adder lane sums.
- `add_out_half`  in  `[1:0][2*EACH_ADDER_LEN:0]`  adder half sums.
- `add_out_full`  in  `[TOTAL:0]`  adder full sum.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  TOTAL  accumulated result.
- `out_ovf`  out  `N_ADDERS`  sticky per-lane carry-out flags.
- `out_count`  out  `ACC_CNT_W`  words accumulated, saturating.

## Operation
- The FSM has three states.
  - IDLE: accumulator = 0.
  - ACCUM: packet in progress.
  - DONE: result held until consumed.
- `in_ready = (state != DONE)`.
- A beat is accepted when `in_valid && in_ready`. On every accepted beat:
  - The accumulator loads the adder result selected by the effective mode. The effective mode is `mode` on the first beat and the latched mode thereafter.
  - Selected result per mode:
    - 8B: lane i = `add_out_quart[i][7:0]`.
    - 16B: half j = `add_out_half[j][15:0]`.
    - 32B: `add_out_full[31:0]`.
  - Sums wrap within the lane; no saturation.
  - Overflow flags are OR-ed in per mode:
    - 8B: `ovf[i] |= add_out_quart[i][8]`.
    - 16B: `ovf[1] |= add_out_half[0][16]` and `ovf[3] |= add_out_half[1][16]`; `ovf[0]` and `ovf[2]` stay 0.
    - 32B: `ovf[3] |= add_out_full[32]`; the other bits stay 0.
  - The count increments and saturates at all-ones.
- State transitions:
  - IDLE, first beat: latch mode. Go to DONE if `in_last`, otherwise ACCUM.
  - ACCUM, beat with `in_last`: go to DONE.
  - DONE: `out_valid = 1`. On `out_ready`, clear the accumulator, flags and count, then go to IDLE.
- `mode` changes during ACCUM/DONE are ignored.
- A one-beat packet goes IDLE→DONE directly.
- In DONE, `in_valid` is back-pressured. A new packet's first beat is accepted no earlier than the cycle after the handshake.

## Timing
- Reset values:
  - state IDLE
  - `out_valid` 0
  - `in_ready` 1
  - `out_data` 0
  - `out_ovf` 0
  - `out_count` 0
  - `add_in1` 0
- The adder path is combinational from `add_in0`/`add_in1` back to `add_out_*` within one cycle. The accumulator is the only register in the loop.
- Latency: `out_valid` rises the cycle after the `in_last` beat is accepted.
- `out_data`/`out_ovf`/`out_count` are registered and stable while `out_valid && !out_ready`.
- Throughput: one word per cycle within a packet. One bubble cycle per packet (DONE).
- Reset asserted mid-packet: the packet is discarded and all outputs return to reset values immediately.

## Structure
- `pe_pkg` holds:
  - `PRECISION_CONFIG_L`
  - `PRECISION_CONFIG_8B`/`_16B`/`_32B`
  - new typedef `acc_state_t` (IDLE, ACCUM, DONE).
- Sub-module `acc_lane_select`: combinational mux of the `add_out_*` inputs to the 32-bit next-accumulator value plus the 4-bit carry vector, per mode. FSM and registers stay in the top module.
- The integration test pairs this block with `adder_decomposable`.

## Test plan
- 8B, beats `0x01020304` then `0xFF0000FF` (last) → `out_data=0x00020303`, `out_ovf=4'b1001`, `out_count=2`.
- 16B, beats `0x0000FFFF` then `0x00000001` (last) → `out_data=0x00000000`, `out_ovf=4'b0010`; no carry into the upper half.
- 32B, beats `0xFFFFFFFF` then `0x00000001` (last) → `out_data=0`, `out_ovf=4'b1000`, `out_count=2`.
- Single-beat packet `0x12345678` (last) in 8B with `out_ready` low for 3 cycles:
  - `out_valid` asserts 1 cycle after acceptance.
  - The result holds with `in_ready=0` until `out_ready`.
  - IDLE follows the handshake.
- `mode` switched from 8B to 32B on beat 2 of a 3-beat packet → result matches pure 8B lane arithmetic.
- `rst` pulsed after beat 2 of 4 → outputs return to reset values immediately. A subsequent packet `0x00000005` (last) yields `out_data=0x00000005`, `out_count=1`.

Source files
------------

// File: rtl/adder_decomposable_accumulator_pkg.sv
// Package pe_pkg: shared definitions for the posit PE datapath.
//   PRECISION_CONFIG_L        width of the precision-mode field
//   PRECISION_CONFIG_8B/16B/32B  lane-split encodings for the decomposable adder
//   acc_state_t               accumulator FSM state (IDLE, ACCUM, DONE)
package pe_pkg;

   localparam int PRECISION_CONFIG_L = 2;

   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd0;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/adder_decomposable_accumulator_acc_lane_select.sv
// acc_lane_select: picks the next accumulator value and carry vector out of
// the decomposable adder's quarter/half/full sums according to the mode.
//   mode           precision mode in effect for this beat
//   add_out_quart  per-lane sums, carry in the top bit
//   add_out_half   half-word sums, carry in the top bit
//   add_out_full   full-word sum, carry in the top bit
//   sum            lane-wrapped next accumulator value
//   carry          carry-out per lane position (16B uses bits 1/3, 32B bit 3)
module acc_lane_select
   import pe_pkg::*;
#(
   parameter int EACH_ADDER_LEN = 8,
   parameter int N_ADDERS       = 4
) (
   input  logic [PRECISION_CONFIG_L-1:0]            mode,
   input  logic [N_ADDERS-1:0][EACH_ADDER_LEN:0]    add_out_quart,
   input  logic [1:0][2*EACH_ADDER_LEN:0]           add_out_half,
   input  logic [EACH_ADDER_LEN*N_ADDERS:0]         add_out_full,
   output logic [EACH_ADDER_LEN*N_ADDERS-1:0]       sum,
   output logic [N_ADDERS-1:0]                      carry
);

   localparam int TOTAL = EACH_ADDER_LEN * N_ADDERS;
   localparam int HALF  = 2 * EACH_ADDER_LEN;

   logic [TOTAL-1:0]    quart_sum;
   logic [N_ADDERS-1:0] quart_carry;
   logic [TOTAL-1:0]    half_sum;
   logic [1:0]          half_carry;

   // Strip carries off the lane sums so every lane wraps independently.
   genvar gi;
   generate
      for (gi = 0; gi < N_ADDERS; gi++) begin : g_quart
         assign quart_sum[gi*EACH_ADDER_LEN +: EACH_ADDER_LEN] = add_out_quart[gi][EACH_ADDER_LEN-1:0];
         assign quart_carry[gi] = add_out_quart[gi][EACH_ADDER_LEN];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_sum[gi*HALF +: HALF] = add_out_half[gi][HALF-1:0];
         assign half_carry[gi] = add_out_half[gi][HALF];
      end
   endgenerate

   // Unused encodings fall back to the 8B split.
   always_comb begin
      sum   = quart_sum;
      carry = quart_carry;
      case (mode)
         PRECISION_CONFIG_16B: begin
            sum   = half_sum;
            carry = {half_carry[1], 1'b0, half_carry[0], 1'b0};
         end
         PRECISION_CONFIG_32B: begin
            sum   = add_out_full[TOTAL-1:0];
            carry = {add_out_full[TOTAL], 3'b000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/adder_decomposable_accumulator.sv
// adder_decomposable_accumulator: accumulates a packet of operand words
// through an external decomposable adder and presents the packet total.
//   clk, rst            clock, asynchronous active-high reset
//   mode                precision mode, sampled on the first beat of a packet
//   in_valid/in_ready   operand word handshake; in_data word, in_last end of packet
//   add_in0/add_in1     adder operands (incoming word, accumulator)
//   add_mode            adder precision mode
//   add_out_*           adder quarter/half/full sums
//   out_valid/out_ready result handshake
//   out_data            packet total, lanes wrap
//   out_ovf             sticky per-lane carry-out flags
//   out_count           beats accumulated, saturating
module adder_decomposable_accumulator
   import pe_pkg::*;
#(
   parameter int EACH_ADDER_LEN = 8,
   parameter int N_ADDERS       = 4,
   parameter int ACC_CNT_W      = 8
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [PRECISION_CONFIG_L-1:0]             mode,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [EACH_ADDER_LEN*N_ADDERS-1:0]        in_data,
   input  logic                                      in_last,
   output logic [EACH_ADDER_LEN*N_ADDERS-1:0]        add_in0,
   output logic [EACH_ADDER_LEN*N_ADDERS-1:0]        add_in1,
   output logic [PRECISION_CONFIG_L-1:0]             add_mode,
   input  logic [N_ADDERS-1:0][EACH_ADDER_LEN:0]     add_out_quart,
   input  logic [1:0][2*EACH_ADDER_LEN:0]            add_out_half,
   input  logic [EACH_ADDER_LEN*N_ADDERS:0]          add_out_full,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [EACH_ADDER_LEN*N_ADDERS-1:0]        out_data,
   output logic [N_ADDERS-1:0]                       out_ovf,
   output logic [ACC_CNT_W-1:0]                      out_count
);

   localparam int TOTAL = EACH_ADDER_LEN * N_ADDERS;

   acc_state_t                    state_reg;
   logic [TOTAL-1:0]              acc_reg;
   logic [N_ADDERS-1:0]           ovf_reg;
   logic [ACC_CNT_W-1:0]          cnt_reg;
   logic [PRECISION_CONFIG_L-1:0] mode_reg;

   logic [PRECISION_CONFIG_L-1:0] eff_mode;
   logic [TOTAL-1:0]              sel_sum;
   logic [N_ADDERS-1:0]           sel_carry;
   logic                          beat;

   // The first beat uses the live mode; later beats use the one latched then.
   assign eff_mode  = (state_reg == ST_IDLE) ? mode : mode_reg;
   assign in_ready  = (state_reg != ST_DONE);
   assign beat      = in_valid && in_ready;

   assign add_in0   = in_data;
   assign add_in1   = acc_reg;
   assign add_mode  = eff_mode;

   assign out_valid = (state_reg == ST_DONE);
   assign out_data  = acc_reg;
   assign out_ovf   = ovf_reg;
   assign out_count = cnt_reg;

   acc_lane_select #(
      .EACH_ADDER_LEN (EACH_ADDER_LEN),
      .N_ADDERS       (N_ADDERS)
   ) u_lane_select (
      .mode          (eff_mode),
      .add_out_quart (add_out_quart),
      .add_out_half  (add_out_half),
      .add_out_full  (add_out_full),
      .sum           (sel_sum),
      .carry         (sel_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         ovf_reg   <= '0;
         cnt_reg   <= '0;
         mode_reg  <= PRECISION_CONFIG_8B;
      end else begin
         if (beat) begin
            acc_reg <= sel_sum;
            ovf_reg <= ovf_reg | sel_carry;
            if (cnt_reg != '1) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == ST_IDLE) begin
               mode_reg <= mode;
            end
            state_reg <= in_last ? ST_DONE : ST_ACCUM;
         end else if ((state_reg == ST_DONE) && out_ready) begin
            // Clearing here guarantees the next packet starts from zero.
            acc_reg   <= '0;
            ovf_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_adder_decomposable_accumulator.sv
module tb_adder_decomposable_accumulator;
   import pe_pkg::*;

   localparam int L = 8;
   localparam int N = 4;
   localparam int T = L * N;
   localparam int CW = 8;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [PRECISION_CONFIG_L-1:0]  mode;
   logic                           in_valid;
   logic                           in_ready;
   logic [T-1:0]                   in_data;
   logic                           in_last;
   logic [T-1:0]                   add_in0;
   logic [T-1:0]                   add_in1;
   logic [PRECISION_CONFIG_L-1:0]  add_mode;
   logic [N-1:0][L:0]              add_out_quart;
   logic [1:0][2*L:0]              add_out_half;
   logic [T:0]                     add_out_full;
   logic                           out_valid;
   logic                           out_ready;
   logic [T-1:0]                   out_data;
   logic [N-1:0]                   out_ovf;
   logic [CW-1:0]                  out_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]                   pkt_words[$];
   logic [PRECISION_CONFIG_L-1:0] pkt_modes[$];
   logic [31:0] exp_data;
   logic [3:0]  exp_ovf;
   int          exp_cnt;

   always #5 clk = ~clk;

   adder_decomposable_accumulator #(
      .EACH_ADDER_LEN (L),
      .N_ADDERS       (N),
      .ACC_CNT_W      (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mode          (mode),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .add_in0       (add_in0),
      .add_in1       (add_in1),
      .add_mode      (add_mode),
      .add_out_quart (add_out_quart),
      .add_out_half  (add_out_half),
      .add_out_full  (add_out_full),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_ovf       (out_ovf),
      .out_count     (out_count)
   );

   // Decomposable adder stand-in: every split is computed; the DUT picks one.
   always_comb begin
      add_out_quart = '0;
      add_out_half  = '0;
      for (int i = 0; i < N; i++)
         add_out_quart[i] = {1'b0, add_in0[i*L +: L]} + {1'b0, add_in1[i*L +: L]};
      for (int j = 0; j < 2; j++)
         add_out_half[j] = {1'b0, add_in0[j*2*L +: 2*L]} + {1'b0, add_in1[j*2*L +: 2*L]};
      add_out_full = {1'b0, add_in0} + {1'b0, add_in1};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: packet mode is the first beat's; each lane is an independent
   // modular sum, with a sticky flag whenever a partial sum exceeds the lane.
   task automatic model();
      int    m, per, nl;
      longint w, mask, part;
      longint acc[4];
      m = int'(pkt_modes[0]);
      if (m > 2) m = 0;
      per  = 1 << m;
      nl   = 4 / per;
      w    = 64'(8 * per);
      mask = (longint'(1) << w) - 1;
      for (int k = 0; k < 4; k++) acc[k] = 0;
      exp_ovf = '0;
      foreach (pkt_words[b]) begin
         for (int k = 0; k < nl; k++) begin
            part = (longint'(pkt_words[b]) >> (k * w)) & mask;
            acc[k] = acc[k] + part;
            if (acc[k] > mask) begin
               exp_ovf[k*per + per - 1] = 1'b1;
               acc[k] = acc[k] & mask;
            end
         end
      end
      exp_data = '0;
      for (int k = 0; k < nl; k++) exp_data = exp_data | 32'(acc[k] << (k * w));
      exp_cnt = (pkt_words.size() > 255) ? 255 : pkt_words.size();
   endtask

   task automatic run_packet(input string name, input int hold);
      model();
      foreach (pkt_words[b]) begin
         @(negedge clk);
         mode     = pkt_modes[b];
         in_data  = pkt_words[b];
         in_valid = 1'b1;
         in_last  = (b == pkt_words.size() - 1);
         if (b < 2) begin
            chk({name, " in_ready"}, 32'(in_ready), 32'd1);
            chk({name, " out_valid_busy"}, 32'(out_valid), 32'd0);
         end
         @(posedge clk);
      end
      @(negedge clk);
      // Junk word held valid during DONE must be back-pressured.
      in_data = 32'hDEADBEEF;
      in_last = 1'b0;
      chk({name, " out_valid"}, 32'(out_valid), 32'd1);
      chk({name, " in_ready_done"}, 32'(in_ready), 32'd0);
      chk({name, " out_data"}, out_data, exp_data);
      chk({name, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
      chk({name, " out_count"}, 32'(out_count), 32'(exp_cnt));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
         chk({name, " hold_data"}, out_data, exp_data);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({name, " idle_valid"}, 32'(out_valid), 32'd0);
      chk({name, " idle_ready"}, 32'(in_ready), 32'd1);
      chk({name, " idle_count"}, 32'(out_count), 32'd0);
      chk({name, " idle_acc"}, add_in1, 32'd0);
      $display("packet %s mode=%0d beats=%0d data=%h ovf=%b count=%0d",
               name, pkt_modes[0], pkt_words.size(), exp_data, exp_ovf, exp_cnt);
   endtask

   task automatic set_pkt(input logic [1:0] m, input logic [31:0] w0, input logic [31:0] w1);
      pkt_words = '{w0, w1};
      pkt_modes = '{m, m};
   endtask

   initial begin
      rst = 1'b1; mode = PRECISION_CONFIG_8B; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_data", out_data, 32'd0);
      chk("rst out_ovf", 32'(out_ovf), 32'd0);
      chk("rst out_count", 32'(out_count), 32'd0);
      chk("rst add_in1", add_in1, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      set_pkt(PRECISION_CONFIG_8B, 32'h01020304, 32'hFF0000FF);
      run_packet("dir8b", 0);
      chk("dir8b const", exp_data, 32'h00020303);
      set_pkt(PRECISION_CONFIG_16B, 32'h0000FFFF, 32'h00000001);
      run_packet("dir16b", 1);
      chk("dir16b const_ovf", 32'(exp_ovf), 32'b0010);
      set_pkt(PRECISION_CONFIG_32B, 32'hFFFFFFFF, 32'h00000001);
      run_packet("dir32b", 0);
      chk("dir32b const_ovf", 32'(exp_ovf), 32'b1000);

      pkt_words = '{32'h12345678};
      pkt_modes = '{PRECISION_CONFIG_8B};
      run_packet("single", 3);

      // Mode flipped mid-packet must not affect the packet.
      pkt_words = '{32'h80F0_10FF, 32'h80F0_F001, 32'h0111_1111};
      pkt_modes = '{PRECISION_CONFIG_8B, PRECISION_CONFIG_32B, PRECISION_CONFIG_32B};
      run_packet("modeswitch", 0);

      // Reset in the middle of a packet.
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mode = PRECISION_CONFIG_8B; in_data = 32'h11111111 * (b + 1);
         in_valid = 1'b1; in_last = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst out_data", out_data, 32'd0);
      chk("midrst out_count", 32'(out_count), 32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst add_in1", add_in1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pkt_words = '{32'h00000005};
      pkt_modes = '{PRECISION_CONFIG_8B};
      run_packet("postrst", 0);

      // Count saturation.
      pkt_words = {};
      pkt_modes = {};
      for (int b = 0; b < 260; b++) begin
         pkt_words.push_back($urandom);
         pkt_modes.push_back(PRECISION_CONFIG_16B);
      end
      run_packet("saturate", 0);

      // Random packets.
      for (int p = 0; p < 25; p++) begin
         logic [1:0] m;
         int len;
         m   = 2'($urandom_range(0, 2));
         len = $urandom_range(1, 6);
         pkt_words = {};
         pkt_modes = {};
         for (int b = 0; b < len; b++) begin
            pkt_words.push_back((p % 3 == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom);
            pkt_modes.push_back(b == 0 ? m : 2'($urandom_range(0, 3)));
         end
         run_packet($sformatf("rand%0d", p), $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
